// File: rtl/score_conv_scheduler.sv
// rtl/score_conv_scheduler.sv - two-team score keeper sharing one bin-to-decimal converter, with 4-digit display scan
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit on the display.
module score_conv_scheduler #(
  parameter int MAX_SCORE = 99,
  parameter int CONV_LAT  = 1,
  parameter int SCAN_DIV  = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       home_inc_i,
  input  logic       home_dec_i,
  input  logic       guest_inc_i,
  input  logic       guest_dec_i,
  input  logic       clear_i,
  output logic [6:0] conv_bin_o,
  input  logic [3:0] conv_tens_i,
  input  logic [3:0] conv_ones_i,
  output logic       busy_o,
  output logic [3:0] digit_sel_o,
  output logic [3:0] bcd_o
);

  localparam int LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_H, CAP_H, WAIT_G, CAP_G} state_t;

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [6:0]    conv_bin_q, conv_bin_d;
  logic [6:0]    home_q, home_d, guest_q, guest_d;
  logic [3:0]    home_tens_q, home_tens_d, home_ones_q, home_ones_d;
  logic [3:0]    guest_tens_q, guest_tens_d, guest_ones_q, guest_ones_d;
  logic [SW-1:0] scan_cnt_q;
  logic [3:0]    digit_sel_q, sel_next;
  logic [3:0]    bcd_q, bcd_next;
  logic          any_pulse;

  assign any_pulse = home_inc_i | home_dec_i | guest_inc_i | guest_dec_i | clear_i;

  always_comb begin
    home_d  = home_q;
    guest_d = guest_q;
    if (clear_i) begin
      home_d  = '0;
      guest_d = '0;
    end else begin
      if (home_inc_i && !home_dec_i && home_q < 7'(MAX_SCORE))
        home_d = home_q + 7'd1;
      else if (home_dec_i && !home_inc_i && home_q != 7'd0)
        home_d = home_q - 7'd1;
      if (guest_inc_i && !guest_dec_i && guest_q < 7'(MAX_SCORE))
        guest_d = guest_q + 7'd1;
      else if (guest_dec_i && !guest_inc_i && guest_q != 7'd0)
        guest_d = guest_q - 7'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    lat_d        = lat_q;
    conv_bin_d   = conv_bin_q;
    home_tens_d  = home_tens_q;
    home_ones_d  = home_ones_q;
    guest_tens_d = guest_tens_q;
    guest_ones_d = guest_ones_q;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          pending_d  = 1'b0;
          conv_bin_d = home_q;
          lat_d      = '0;
          state_d    = WAIT_H;
        end
      end
      WAIT_H: begin
        if (lat_q == LW'(CONV_LAT - 1)) state_d = CAP_H;
        else                            lat_d   = lat_q + 1'b1;
      end
      CAP_H: begin
        home_tens_d = conv_tens_i;
        home_ones_d = conv_ones_i;
        conv_bin_d  = guest_q;
        lat_d       = '0;
        state_d     = WAIT_G;
      end
      WAIT_G: begin
        if (lat_q == LW'(CONV_LAT - 1)) state_d = CAP_G;
        else                            lat_d   = lat_q + 1'b1;
      end
      CAP_G: begin
        guest_tens_d = conv_tens_i;
        guest_ones_d = conv_ones_i;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A pulse arriving while IDLE consumes pending must still request another pass.
    if (any_pulse) pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      lat_q        <= '0;
      conv_bin_q   <= '0;
      home_q       <= '0;
      guest_q      <= '0;
      home_tens_q  <= '0;
      home_ones_q  <= '0;
      guest_tens_q <= '0;
      guest_ones_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      lat_q        <= lat_d;
      conv_bin_q   <= conv_bin_d;
      home_q       <= home_d;
      guest_q      <= guest_d;
      home_tens_q  <= home_tens_d;
      home_ones_q  <= home_ones_d;
      guest_tens_q <= guest_tens_d;
      guest_ones_q <= guest_ones_d;
    end
  end

  assign sel_next = {digit_sel_q[0], digit_sel_q[3:1]};

  always_comb begin
    bcd_next = 4'd0;
    case (sel_next)
      4'b1000: bcd_next = home_tens_q;
      4'b0100: bcd_next = home_ones_q;
      4'b0010: bcd_next = guest_tens_q;
      4'b0001: bcd_next = guest_ones_q;
      default: bcd_next = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((sel_next[3] && home_tens_q == 4'd0) || (sel_next[1] && guest_tens_q == 4'd0))
      bcd_next = 4'hF;
`endif
  end

  // Digits are sampled at selection time, so a latch update shows on the next visit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= 4'b1000;
      bcd_q       <= 4'd0;
    end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= sel_next;
      bcd_q       <= bcd_next;
    end else begin
      scan_cnt_q  <= scan_cnt_q + 1'b1;
    end
  end

  assign conv_bin_o  = conv_bin_q;
  assign busy_o      = (state_q != IDLE) | pending_q;
  assign digit_sel_o = digit_sel_q;
  assign bcd_o       = bcd_q;

endmodule
